fp_div: RTL and testbench
=========================

FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 SHALL have parameter EXP_BIAS, default 127, the IEEE-754 single-precision exponent bias.
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to divide a by b; sampled only in IDLE.
REQ-005 SHALL have port a  input  32  dividend, IEEE-754 single.
REQ-006 SHALL have port b  input  32  divisor, IEEE-754 single.
REQ-007 SHALL have port result  output  32  quotient, registered, held until the next accepted start.
REQ-008 SHALL have port busy  output  1  high in SETUP, DIVIDE and NORM.
REQ-009 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-010 SHALL have port div_by_zero  output  1  flag for the current result, held with result.

Function
REQ-011 SHALL implement states IDLE, SETUP, DIVIDE, NORM and DONE; DONE SHALL go to IDLE on the next edge.
REQ-012 SHALL accept start only in IDLE, capturing a and b on that edge, and SHALL ignore start in every other state.
REQ-013 SETUP SHALL unpack both operands:
  - sign = a[31] xor b[31];
  - mantissas {1,frac}, 24 bits;
  - exponent e = ea - eb + EXP_BIAS as a 10-bit signed value.
REQ-014 SETUP special cases SHALL go straight to DONE:
  - b exponent 0 (zero or denormal): result {sign,0xFF,0}, div_by_zero=1;
  - else a exponent 0: result {sign,0x00,0}, div_by_zero=0.
REQ-015 Operands with exponent 0xFF are out of scope: result is unspecified, but done SHALL still occur at normal latency.
REQ-016 DIVIDE SHALL run restoring division for exactly 26 cycles, one quotient bit per cycle, MSB first, into q[25:0].
  - Remainder starts at the dividend mantissa.
  - Each cycle: if rem >= mb then rem = (rem - mb) << 1 and the bit is 1, else rem = rem << 1 and the bit is 0.
  - A 5-bit counter controls the loop.
REQ-017 NORM SHALL normalize:
  - q[25]=1: mant = q[24:2], guard = q[1];
  - q[25]=0: mant = q[23:1], guard = q[0], and e = e - 1.
REQ-018 After rounding, e >= 255 SHALL give {sign,0xFF,0} (div_by_zero=0), and e <= 0 SHALL give signed zero (denormals flushed).
REQ-019 Latency SHALL be counted in rising edges, from the edge sampling start through the edge asserting done:
  - normal path: 29 edges;
  - special-case path: 2 edges.
REQ-020 busy SHALL fall on the same edge that done rises.

Reset
REQ-021 While rst is high at a clock edge, the block SHALL enter IDLE and clear result, busy, done, div_by_zero, counter, quotient and remainder.
REQ-022 Reset in any non-IDLE state SHALL abort the operation with no done pulse, and a start after reset SHALL work normally.

Configuration
REQ-023 With macro FPDIV_ROUND_EN defined, NORM SHALL add guard to mant; a carry out of mant[22] SHALL set mant=0 and e=e+1.
REQ-024 Without FPDIV_ROUND_EN, NORM SHALL truncate (guard ignored); latency and all other behaviour are identical.

Verification
REQ-025 a=0x40C00000 (6.0), b=0x40000000 (2.0) -> result 0x40400000, div_by_zero=0, done at edge 29, busy low with done.
REQ-026 a=0x3F800000 (1.0), b=0x40400000 (3.0) -> result 0x3EAAAAAB with FPDIV_ROUND_EN, 0x3EAAAAAA without.
REQ-027 a=0x3F800000 / b=0x00000000 -> 0x7F800000 with div_by_zero=1 at edge 2; a=0xBF800000 / b=0 -> 0xFF800000.
REQ-028 a=0x80000000 (-0.0), b=0x40A00000 (5.0) -> 0x80000000 at edge 2; a=0xC0F00000 (-7.5), b=0x40200000 (2.5) -> 0xC0400000.
REQ-029 a=0x7F000000, b=0x00800000 -> 0x7F800000 with div_by_zero=0 (overflow).
REQ-030 Control sequence:
  - start pulsed during DIVIDE SHALL be ignored, giving exactly one done;
  - rst at DIVIDE cycle 10 SHALL drop busy with no done;
  - a following 6.0/2.0 SHALL give 0x40400000 at edge 29.

Source files
------------

// File: rtl/fp_div.sv
// fp_div: multi-cycle IEEE-754 single-precision divider.
// The quotient mantissa comes from a 26-step restoring division, one bit per cycle.
// Denormal inputs are treated as zero, and results that underflow are flushed to zero.
// Optional macro FPDIV_ROUND_EN: add the guard bit to the mantissa. When the macro
// is not defined, the mantissa is truncated.
module fp_div #(
    parameter int EXP_BIAS = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        DIVIDE = 3'd2,
        NORM   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [4:0] LAST_STEP = 5'd25;

    state_t             state;
    state_t             state_nxt;

    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic               sign;
    logic signed [9:0]  e;
    logic [23:0]        mb;
    logic [25:0]        rem;
    logic [25:0]        q;
    logic [4:0]         cnt;

    logic [7:0]         ea;
    logic [7:0]         eb;
    logic               sign_w;
    logic               rem_ge;

    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign sign_w = a_q[31] ^ b_q[31];
    assign rem_ge = (rem >= {2'b00, mb});

`ifndef FPDIV_ROUND_EN
    // The lowest quotient bit is only a guard bit, and only the rounding build reads it.
    logic unused_guard;
    assign unused_guard = q[0];
`endif

    // Normalise the raw quotient, round or truncate it, then clamp to infinity or flush to zero.
    function automatic logic [31:0] pack_quotient(input logic              s,
                                                  input logic [25:0]       qv,
                                                  input logic signed [9:0] ev);
        logic [22:0]       m;
        logic signed [9:0] en;
`ifdef FPDIV_ROUND_EN
        logic              g;
        logic [23:0]       sum;
`endif
        if (qv[25]) begin
            m  = qv[24:2];
            en = ev;
        end else begin
            m  = qv[23:1];
            en = ev - 10'sd1;
        end
`ifdef FPDIV_ROUND_EN
        g   = qv[25] ? qv[1] : qv[0];
        sum = {1'b0, m} + {23'd0, g};
        if (sum[23]) begin
            m  = 23'd0;
            en = en + 10'sd1;
        end else begin
            m  = sum[22:0];
        end
`endif
        if (en >= 10'sd255)
            pack_quotient = {s, 8'hFF, 23'd0};
        else if (en <= 10'sd0)
            pack_quotient = {s, 31'd0};
        else
            pack_quotient = {s, en[7:0], m};
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic. Special operands skip the divide loop.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETUP;
            SETUP:   state_nxt = (eb == 8'd0 || ea == 8'd0) ? DONE : DIVIDE;
            DIVIDE:  if (cnt == LAST_STEP) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered from the next state, so busy falls on the edge where done rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == SETUP) || (state_nxt == DIVIDE) || (state_nxt == NORM);
            done <= (state_nxt == DONE);
        end
    end

    // Datapath: capture operands, unpack them, run the restoring divide, then pack the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            sign        <= 1'b0;
            e           <= 10'sd0;
            mb          <= 24'd0;
            rem         <= 26'd0;
            q           <= 26'd0;
            cnt         <= 5'd0;
            result      <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q <= a;
                        b_q <= b;
                    end
                end
                SETUP: begin
                    sign <= sign_w;
                    e    <= 10'($signed({2'b00, ea}) - $signed({2'b00, eb}) + EXP_BIAS);
                    mb   <= {1'b1, b_q[22:0]};
                    rem  <= {2'b01, a_q[22:0]};
                    q    <= 26'd0;
                    cnt  <= 5'd0;
                    if (eb == 8'd0) begin
                        result      <= {sign_w, 8'hFF, 23'd0};
                        div_by_zero <= 1'b1;
                    end else if (ea == 8'd0) begin
                        result      <= {sign_w, 31'd0};
                        div_by_zero <= 1'b0;
                    end
                end
                DIVIDE: begin
                    if (rem_ge)
                        rem <= (rem - {2'b00, mb}) << 1;
                    else
                        rem <= rem << 1;
                    q   <= {q[24:0], rem_ge};
                    cnt <= cnt + 5'd1;
                end
                NORM: begin
                    result      <= pack_quotient(sign, q, e);
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: scoreboard bench for fp_div. It checks directed vectors, random
// normal operands, special cases, and the control sequences.
// Build with +define+FPDIV_ROUND_EN to check the rounding variant.
module tb_fp_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;

    fp_div #(.EXP_BIAS(127)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .result      (result),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: one integer division gives the 26-bit quotient, then the normalise, round and clamp rules are applied.
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input string tag);
        exp_t        r;
        logic        s;
        int          ea, eb, e;
        logic [63:0] num, qq;
        logic [25:0] q;
        logic [22:0] m;
        s     = av[31] ^ bv[31];
        ea    = int'(av[30:23]);
        eb    = int'(bv[30:23]);
        r.tag = tag;
        r.dbz = 1'b0;
        r.lat = 29;
        if (eb == 0) begin
            r.res = {s, 8'hFF, 23'd0};
            r.dbz = 1'b1;
            r.lat = 2;
        end else if (ea == 0) begin
            r.res = {s, 31'd0};
            r.lat = 2;
        end else begin
            num = {40'd0, 1'b1, av[22:0]} << 25;
            qq  = num / {40'd0, 1'b1, bv[22:0]};
            q   = qq[25:0];
            e   = ea - eb + 127;
            if (q[25]) m = q[24:2];
            else begin m = q[23:1]; e = e - 1; end
`ifdef FPDIV_ROUND_EN
            if (q[25] ? q[1] : q[0]) begin
                if (m == 23'h7FFFFF) begin m = 23'd0; e = e + 1; end
                else m = m + 23'd1;
            end
`endif
            if (e >= 255)     r.res = {s, 8'hFF, 23'd0};
            else if (e <= 0)  r.res = {s, 31'd0};
            else              r.res = {s, e[7:0], m};
        end
        return r;
    endfunction

    // Push the expectation, launch the divide, and compare when done rises.
    // If mid is nonzero, a second start pulse is driven after that many edges; the DUT must ignore it.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input exp_t ex, input int mid);
        exp_t got_ex;
        int   n;
        bit   seen;
        sb.push_back(ex);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        seen = 0;
        check({ex.tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (mid != 0 && n == mid) begin
                start = 1'b1;
                a = 32'h3F800000;
                b = 32'h40400000;
            end
            if (done) seen = 1;
        end
        start = 1'b0;
        got_ex = sb.pop_front();
        if (!seen) begin
            check({got_ex.tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({got_ex.tag, "_result"}, result, got_ex.res);
            check({got_ex.tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, got_ex.dbz});
            check({got_ex.tag, "_latency"}, n, got_ex.lat);
            check({got_ex.tag, "_busy_with_done"}, {31'd0, busy}, 32'd0);
            @(posedge clk); #1;
            check({got_ex.tag, "_done_pulse"}, {31'd0, done}, 32'd0);
            check({got_ex.tag, "_result_hold"}, result, got_ex.res);
        end
    endtask

    task automatic run(input logic [31:0] av, input logic [31:0] bv, input string tag);
        issue(av, bv, model(av, bv, tag), 0);
    endtask

    task automatic run_const(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] res,
                             input logic dbz, input int lat, input string tag);
        exp_t ex;
        ex.res = res; ex.dbz = dbz; ex.lat = lat; ex.tag = tag;
        issue(av, bv, ex, 0);
    endtask

    initial begin
        exp_t ex;
        int   dc;
        rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk) rst = 1'b0;

        run_const(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29, "six_div_two");
`ifdef FPDIV_ROUND_EN
        run_const(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 29, "one_div_three");
`else
        run_const(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 29, "one_div_three");
`endif
        run_const(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 2, "pos_div_zero");
        run_const(32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 2, "neg_div_zero");
        run_const(32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 2, "negzero_div");
        run_const(32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0, 29, "neg7p5_div_2p5");
        run_const(32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 29, "overflow");
        run_const(32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 29, "underflow");
        run_const(32'h3F800000, 32'h00400000, 32'h7F800000, 1'b1, 2, "denorm_divisor");
        run_const(32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 2, "denorm_dividend");

        for (int i = 0; i < 24; i++) begin
            logic [31:0] av, bv;
            av = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            bv = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            run(av, bv, $sformatf("rand%0d", i));
        end

        // A start pulse during DIVIDE must be ignored: exactly one done, with the original operands.
        dc = done_cnt;
        ex.res = 32'h40400000; ex.dbz = 1'b0; ex.lat = 29; ex.tag = "ignored_start";
        issue(32'h40C00000, 32'h40000000, ex, 8);
        repeat (35) @(posedge clk);
        #1;
        check("ignored_start_done_count", done_cnt - dc, 1);

        // Reset asserted in DIVIDE cycle 10 aborts the operation, with no done pulse.
        dc = done_cnt;
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (35) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - dc, 0);
        check("abort_idle_busy", {31'd0, busy}, 32'd0);

        run_const(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
